// File: rtl/axil_core_master.sv
// Single-outstanding AXI4-Lite initiator: turns a CPU req/gnt data port into one
// AW+W/B write or AR/R read, with a watchdog that aborts transactions no slave answers.
module axil_core_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                gnt,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  output logic                m_rready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_BWAIT, S_READ, S_RWAIT} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_aw_done, r_w_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_be;
  logic                r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                r_rvalid, r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic w_idle, w_to, w_aw_hs, w_w_hs, w_aw_done, w_w_done;

  assign w_idle    = (r_state == S_IDLE);
  // Watchdog fires in the last allowed cycle; completing handshakes are checked first below.
  assign w_to      = (TIMEOUT > 0) && !w_idle && (r_cnt == LIMIT);
  assign w_aw_hs   = r_awvalid & m_awready;
  assign w_w_hs    = r_wvalid & m_wready;
  assign w_aw_done = r_aw_done | w_aw_hs;
  assign w_w_done  = r_w_done | w_w_hs;

  assign gnt       = w_idle & req & ~rst;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign m_awaddr  = r_addr;
  assign m_araddr  = r_addr;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_be;
  assign m_awvalid = r_awvalid;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      if (!w_idle) r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (req) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= be;
            r_cnt   <= '0;
            if (we) begin
              r_state   <= S_WRITE;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_READ;
              r_arvalid <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          if (w_to) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_rvalid  <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            if (w_aw_hs) begin
              r_awvalid <= 1'b0;
              r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
              r_wvalid <= 1'b0;
              r_w_done <= 1'b1;
            end
            if (w_aw_done && w_w_done) begin
              r_bready <= 1'b1;
              r_state  <= S_BWAIT;
            end
          end
        end

        S_BWAIT: begin
          if (m_bvalid) begin
            r_bready <= 1'b0;
            r_rvalid <= 1'b1;
            r_state  <= S_IDLE;
          end else if (w_to) begin
            r_bready <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= S_IDLE;
          end
        end

        S_READ: begin
          if (w_to) begin
            r_arvalid <= 1'b0;
            r_rvalid  <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
          end else if (m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RWAIT;
          end
        end

        S_RWAIT: begin
          if (m_rvalid) begin
            r_rready <= 1'b0;
            r_rvalid <= 1'b1;
            r_rdata  <= m_rdata;
            r_state  <= S_IDLE;
          end else if (w_to) begin
            r_rready <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_core_master.sv
// Directed bench for axil_core_master: cycle-by-cycle slave stimulus with hand-computed expectations.
module tb_axil_core_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic        m_arready = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  int checks = 0;
  int errors = 0;

  axil_core_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    smp();
    checks++;
    if ({gnt, rvalid, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {gnt, rvalid, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    checks++;
    if ({rdata, m_awaddr, m_wdata, m_araddr, m_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h awaddr=%h wdata=%h araddr=%h wstrb=%h want all 0",
               rdata, m_awaddr, m_wdata, m_araddr, m_wstrb);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_write_basic();
    req = 1; we = 1; addr = 32'h0000_0004; wdata = 32'h0000_A5A5; be = 4'hF;
    smp();
    checks++;
    if (gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", gnt); end
    cyc(); // cycle 1
    req = 0; m_awready = 1; m_wready = 1;
    smp();
    checks++;
    if ({m_awvalid, m_wvalid} !== 2'b11) begin
      errors++; $display("FAIL wr_valids_c1: got %b want 11", {m_awvalid, m_wvalid});
    end
    checks++;
    if (m_awaddr !== 32'h4 || m_wdata !== 32'hA5A5 || m_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL wr_payload: awaddr=%h wdata=%h wstrb=%h want 4/a5a5/f", m_awaddr, m_wdata, m_wstrb);
    end
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt_busy: got %b want 0", gnt); end
    cyc(); // cycle 2
    m_awready = 0; m_wready = 0; m_bvalid = 1;
    smp();
    checks++;
    if ({m_bready, m_awvalid, m_wvalid, rvalid} !== 4'b1000) begin
      errors++; $display("FAIL wr_bwait: bready/awv/wv/rvalid got %b want 1000",
                         {m_bready, m_awvalid, m_wvalid, rvalid});
    end
    cyc(); // cycle 3
    m_bvalid = 0;
    smp();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL wr_resp: rvalid=%b err=%b rdata=%h want 1/0/0", rvalid, err, rdata);
    end
    cyc(); // cycle 4
    smp();
    checks++;
    if (rvalid !== 1'b0 || m_bready !== 1'b0) begin
      errors++; $display("FAIL wr_pulse: rvalid=%b bready=%b want 0/0", rvalid, m_bready);
    end
    cyc();
  endtask

  task automatic test_read_delay();
    req = 1; we = 0; addr = 32'h0000_1008;
    smp();
    checks++;
    if (gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", gnt); end
    for (int c = 1; c <= 3; c++) begin
      cyc();
      req = 0;
      m_arready = (c == 3);
      smp();
      checks++;
      if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_1008) begin
        errors++; $display("FAIL rd_ar_hold c%0d: arvalid=%b araddr=%h want 1/1008", c, m_arvalid, m_araddr);
      end
    end
    cyc(); // cycle 4
    m_arready = 0;
    smp();
    checks++;
    if (m_arvalid !== 1'b0 || m_rready !== 1'b1) begin
      errors++; $display("FAIL rd_rwait: arvalid=%b rready=%b want 0/1", m_arvalid, m_rready);
    end
    cyc(); // cycle 5
    cyc(); // cycle 6
    m_rvalid = 1; m_rdata = 32'h1234_5678;
    smp();
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_early: rvalid=%b want 0", rvalid); end
    cyc(); // cycle 7
    m_rvalid = 0; m_rdata = 32'hFFFF_FFFF;
    smp();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL rd_resp: rvalid=%b err=%b rdata=%h want 1/0/12345678", rvalid, err, rdata);
    end
    cyc(); // cycle 8
    smp();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL rd_pulse: rvalid=%b rdata=%h want 0/0", rvalid, rdata);
    end
    cyc();
  endtask

  task automatic test_split_write();
    req = 1; we = 1; addr = 32'h0000_0020; wdata = 32'hDEAD_BEEF; be = 4'h3;
    smp();
    cyc(); // cycle 1
    req = 0; m_awready = 1;
    smp();
    checks++;
    if ({m_awvalid, m_wvalid} !== 2'b11 || m_wstrb !== 4'h3) begin
      errors++; $display("FAIL sp_c1: valids=%b wstrb=%h want 11/3", {m_awvalid, m_wvalid}, m_wstrb);
    end
    for (int c = 2; c <= 4; c++) begin
      cyc();
      m_awready = 0;
      m_wready = (c == 4);
      smp();
      checks++;
      if ({m_awvalid, m_wvalid, m_bready} !== 3'b010) begin
        errors++; $display("FAIL sp_hold c%0d: awv/wv/bready got %b want 010", c,
                           {m_awvalid, m_wvalid, m_bready});
      end
    end
    cyc(); // cycle 5
    m_wready = 0; m_bvalid = 1;
    smp();
    checks++;
    if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) begin
      errors++; $display("FAIL sp_bready: awv/wv/bready got %b want 001", {m_awvalid, m_wvalid, m_bready});
    end
    cyc(); // cycle 6
    m_bvalid = 0;
    smp();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL sp_resp: rvalid=%b err=%b want 1/0", rvalid, err);
    end
    cyc();
  endtask

  task automatic test_timeout();
    req = 1; we = 0; addr = 32'h0000_6000;
    smp();
    for (int c = 1; c <= 8; c++) begin
      cyc();
      req = 0;
      smp();
      checks++;
      if (m_arvalid !== 1'b1 || rvalid !== 1'b0) begin
        errors++; $display("FAIL to_hold c%0d: arvalid=%b rvalid=%b want 1/0", c, m_arvalid, rvalid);
      end
    end
    cyc(); // cycle 9: abort response, and a new request granted alongside it
    req = 1; we = 0; addr = 32'h0000_1000;
    smp();
    checks++;
    if (m_arvalid !== 1'b0 || rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
      errors++; $display("FAIL to_abort: arvalid=%b rvalid=%b err=%b rdata=%h want 0/1/1/0",
                         m_arvalid, rvalid, err, rdata);
    end
    checks++;
    if (gnt !== 1'b1) begin errors++; $display("FAIL to_regnt: gnt=%b want 1", gnt); end
    cyc(); // cycle 10
    req = 0; m_arready = 1;
    smp();
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0000_1000 || rvalid !== 1'b0) begin
      errors++; $display("FAIL to_next_ar: arvalid=%b araddr=%h rvalid=%b want 1/1000/0",
                         m_arvalid, m_araddr, rvalid);
    end
    cyc(); // cycle 11
    m_arready = 0; m_rvalid = 1; m_rdata = 32'hCAFE_F00D;
    smp();
    cyc(); // cycle 12
    m_rvalid = 0;
    smp();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL to_next_resp: rvalid=%b err=%b rdata=%h want 1/0/cafef00d", rvalid, err, rdata);
    end
    cyc();
  endtask

  task automatic test_limit_completion();
    req = 1; we = 0; addr = 32'h0000_2000;
    smp();
    cyc(); // cycle 1
    req = 0; m_arready = 1;
    smp();
    cyc(); // cycle 2
    m_arready = 0;
    for (int c = 3; c <= 8; c++) cyc();
    m_rvalid = 1; m_rdata = 32'h0BAD_BEEF; // cycle 8: counter at TIMEOUT-1
    smp();
    checks++;
    if (m_rready !== 1'b1 || rvalid !== 1'b0) begin
      errors++; $display("FAIL lim_rready: rready=%b rvalid=%b want 1/0", m_rready, rvalid);
    end
    cyc(); // cycle 9
    m_rvalid = 0;
    smp();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h0BAD_BEEF) begin
      errors++; $display("FAIL lim_resp: rvalid=%b err=%b rdata=%h want 1/0/0badbeef", rvalid, err, rdata);
    end
    cyc(); // cycle 10
    smp();
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL lim_after: rvalid=%b err=%b want 0/0", rvalid, err);
    end
    cyc();
  endtask

  task automatic test_reset_bwait();
    req = 1; we = 1; addr = 32'h0000_0030; wdata = 32'h1111_2222; be = 4'hF;
    smp();
    cyc(); // cycle 1
    req = 0; m_awready = 1; m_wready = 1;
    smp();
    cyc(); // cycle 2: BWAIT, reset applied at the end of it
    m_awready = 0; m_wready = 0; rst = 1;
    smp();
    checks++;
    if (m_bready !== 1'b1) begin errors++; $display("FAIL rst_pre_bready: got %b want 1", m_bready); end
    cyc(); // cycle 3
    rst = 0; req = 1; we = 0; addr = 32'h0000_0044;
    smp();
    checks++;
    if ({rvalid, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 7'h00) begin
      errors++; $display("FAIL rst_ctrl: got %b want 0000000",
                         {rvalid, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    checks++;
    if ({rdata, m_awaddr, m_wdata, m_wstrb} !== '0) begin
      errors++; $display("FAIL rst_data: rdata=%h awaddr=%h wdata=%h wstrb=%h want 0",
                         rdata, m_awaddr, m_wdata, m_wstrb);
    end
    checks++;
    if (gnt !== 1'b1) begin errors++; $display("FAIL rst_regnt: gnt=%b want 1", gnt); end
    cyc(); // cycle 4
    req = 0; m_arready = 1;
    smp();
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h44 || rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_next_ar: arvalid=%b araddr=%h rvalid=%b want 1/44/0",
                         m_arvalid, m_araddr, rvalid);
    end
    cyc(); // cycle 5
    m_arready = 0; m_rvalid = 1; m_rdata = 32'h0000_0055;
    smp();
    cyc(); // cycle 6
    m_rvalid = 0;
    smp();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'h55) begin
      errors++; $display("FAIL rst_next_resp: rvalid=%b err=%b rdata=%h want 1/0/55", rvalid, err, rdata);
    end
    cyc();
  endtask

  initial begin
    repeat (2) cyc();
    test_reset();
    test_write_basic();
    test_read_delay();
    test_split_write();
    test_timeout();
    test_limit_completion();
    test_reset_bwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
